// File: rtl/ctr_drbg_generate.sv
// ctr_drbg_generate: CTR_DRBG generate sequencer with XOR block function E(K,V) = V ^ K.
module ctr_drbg_generate #(
  parameter int BLOCKLEN        = 128,
  parameter int KEYLEN          = 128,
  parameter int SEEDLEN         = 256,
  parameter int RESEED_INTERVAL = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEYLEN-1:0]   Key_in,
  input  logic [BLOCKLEN-1:0] V_in,
  input  logic [31:0]         reseed_counter_in,
  input  logic [SEEDLEN-1:0]  additional_input,
  input  logic                addin_valid,
  input  logic [7:0]          num_blocks,
  output logic [BLOCKLEN-1:0] block_data,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                busy,
  output logic                done,
  output logic                reseed_required,
  output logic [KEYLEN-1:0]   Key_out,
  output logic [BLOCKLEN-1:0] V_out,
  output logic [31:0]         reseed_counter_out
);
  typedef enum logic [2:0] {IDLE, UPD_A1, UPD_A2, GEN, UPD_F1, UPD_F2, DONE} state_t;
  state_t state, state_nxt;
  logic [KEYLEN-1:0]   k;
  logic [BLOCKLEN-1:0] v, tmp_hi, v_inc, e_inc;
  logic [SEEDLEN-1:0]  seed, t;
  logic [7:0]          cnt;
  logic [31:0]         ctr;
  logic                refuse, accept;
  assign v_inc       = v + BLOCKLEN'(1);
  assign e_inc       = v_inc ^ k;
  assign t           = {tmp_hi, e_inc} ^ seed;
  assign refuse      = reseed_counter_in > 32'(RESEED_INTERVAL);
  assign block_valid = state == GEN;
  assign block_data  = block_valid ? e_inc : '0;
  assign accept      = block_valid & block_ready;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = refuse ? DONE : addin_valid ? UPD_A1 : (num_blocks != 8'd0) ? GEN : UPD_F1;
      UPD_A1:  state_nxt = UPD_A2;
      UPD_A2:  state_nxt = (cnt != 8'd0) ? GEN : UPD_F1;
      GEN:     if (accept && cnt == 8'd1) state_nxt = UPD_F1;
      UPD_F1:  state_nxt = UPD_F2;
      UPD_F2:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k                  <= '0;
      v                  <= '0;
      tmp_hi             <= '0;
      seed               <= '0;
      cnt                <= '0;
      ctr                <= '0;
      reseed_required    <= 1'b0;
      Key_out            <= '0;
      V_out              <= '0;
      reseed_counter_out <= '0;
    end else begin
      if (state == IDLE && start) begin
        k               <= Key_in;
        v               <= V_in;
        ctr             <= reseed_counter_in;
        seed            <= addin_valid ? additional_input : '0;
        cnt             <= num_blocks;
        reseed_required <= refuse;
        // a refused request reports its inputs back untouched
        if (refuse) begin
          Key_out            <= Key_in;
          V_out              <= V_in;
          reseed_counter_out <= reseed_counter_in;
        end
      end
      if (state == UPD_A1 || state == UPD_F1) begin
        v      <= v_inc;
        tmp_hi <= e_inc;
      end
      if (state == UPD_A2 || state == UPD_F2) begin
        k <= t[SEEDLEN-1:BLOCKLEN];
        v <= t[BLOCKLEN-1:0];
      end
      if (state == UPD_F2) begin
        Key_out            <= t[SEEDLEN-1:BLOCKLEN];
        V_out              <= t[BLOCKLEN-1:0];
        reseed_counter_out <= ctr + 32'd1;
      end
      if (accept) begin
        v   <= v_inc;
        cnt <= cnt - 8'd1;
      end
    end
endmodule

// File: tb/tb_ctr_drbg_generate.sv
// tb_ctr_drbg_generate: table-driven directed vectors plus backpressure and reset-abort sequences.
module tb_ctr_drbg_generate;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, addin_valid = 1'b0, block_ready = 1'b1;
  logic [127:0] key_in = '0, v_in = '0;
  logic [31:0]  ctr_in = '0;
  logic [255:0] addin = '0;
  logic [7:0]   num_blocks = '0;
  logic [127:0] block_data, key_out, v_out;
  logic         block_valid, busy, done, reseed_required;
  logic [31:0]  ctr_out;
  ctr_drbg_generate dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Key_in(key_in), .V_in(v_in),
    .reseed_counter_in(ctr_in), .additional_input(addin), .addin_valid(addin_valid),
    .num_blocks(num_blocks), .block_data(block_data), .block_valid(block_valid),
    .block_ready(block_ready), .busy(busy), .done(done), .reseed_required(reseed_required),
    .Key_out(key_out), .V_out(v_out), .reseed_counter_out(ctr_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [127:0] key, v;
    logic [31:0]  ctr;
    logic         av;
    logic [255:0] ai;
    logic [7:0]   nb;
    logic [127:0] ek, ev;
    logic [31:0]  ec;
    logic         err;
    logic [127:0] eb0;
    int           enb, elat;
  } vec_t;
  vec_t         vt[7];
  int           n_chk = 0, n_fail = 0;
  int           nblk, ndone, lat;
  logic         got_rr;
  logic [127:0] blks[16];
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t x);
    @(negedge clk);
    key_in = x.key; v_in = x.v; ctr_in = x.ctr; addin_valid = x.av; addin = x.ai;
    num_blocks = x.nb; block_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nblk = 0; ndone = 0; lat = -1; got_rr = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (block_valid && block_ready && nblk < 16) begin
        blks[nblk] = block_data;
        nblk++;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          got_rr = reseed_required;
        end
      end
      if (lat >= 0 && c >= lat + 2) break;
      @(negedge clk);
    end
    if (lat < 0) chk("done_timeout", 256'(0), 256'(1));
  endtask
  task automatic check_vec(input int i);
    chk($sformatf("v%0d_nblocks", i), 256'(nblk), 256'(vt[i].enb));
    if (vt[i].enb > 0) chk($sformatf("v%0d_block0", i), 256'(blks[0]), 256'(vt[i].eb0));
    chk($sformatf("v%0d_key_out", i), 256'(key_out), 256'(vt[i].ek));
    chk($sformatf("v%0d_v_out", i), 256'(v_out), 256'(vt[i].ev));
    chk($sformatf("v%0d_ctr_out", i), 256'(ctr_out), 256'(vt[i].ec));
    chk($sformatf("v%0d_reseed_req", i), 256'(got_rr), 256'(vt[i].err));
    chk($sformatf("v%0d_done_count", i), 256'(ndone), 256'(1));
    chk($sformatf("v%0d_latency", i), 256'(lat), 256'(vt[i].elat));
  endtask
  initial begin
    vt[0] = '{128'h0, 128'h0, 32'd5, 1'b0, 256'h0, 8'd2, 128'h3, 128'h4, 32'd6, 1'b0, 128'h1, 2, 4};
    vt[1] = '{128'h0, 128'h0, 32'd0, 1'b1, {128'h1, 128'h1}, 8'd1, 128'h4, 128'h7, 32'd1, 1'b0, 128'h4, 1, 5};
    vt[2] = '{128'h55, 128'h77, 32'd1001, 1'b0, 256'h0, 8'd3, 128'h55, 128'h77, 32'd1001, 1'b1, 128'h0, 0, 0};
    vt[3] = '{128'h0, {128{1'b1}}, 32'd0, 1'b0, 256'h0, 8'd1, 128'h1, 128'h2, 32'd1, 1'b0, 128'h0, 1, 3};
    vt[4] = '{128'h0, 128'h0, 32'd1000, 1'b0, 256'h0, 8'd0, 128'h1, 128'h2, 32'd1001, 1'b0, 128'h0, 0, 2};
    vt[5] = '{128'h5, 128'h10, 32'd7, 1'b0, 256'h0, 8'd1, 128'h17, 128'h16, 32'd8, 1'b0, 128'h14, 1, 3};
    vt[6] = '{128'h0, 128'h0, 32'd2, 1'b1, {128'h2, 128'h3}, 8'd0, 128'h3, 128'h3, 32'd3, 1'b0, 128'h0, 0, 4};
    repeat (2) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_outputs", {block_data, key_out}, 256'(0));
    chk("rst_misc", {v_out, ctr_out, block_valid, done, reseed_required}, 256'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(vt[i]);
      check_vec(i);
      if (i == 0) chk("v0_block1", 256'(blks[1]), 256'(2));
      if (i == 2) begin
        repeat (3) @(negedge clk);
        chk("reseed_req_held", 256'(reseed_required), 256'(1));
      end
    end
    // backpressure mid-stream with ignored start pulses
    @(negedge clk);
    key_in = '0; v_in = '0; ctr_in = '0; addin_valid = 1'b0; num_blocks = 8'd3;
    block_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_block1", 256'(block_data), 256'(1));
    @(negedge clk);
    block_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_stall%0d", c), {127'(0), block_valid, block_data}, {127'(0), 1'b1, 128'h2});
      if (c == 1) begin
        key_in = {128{1'b1}}; ctr_in = 32'd9; num_blocks = 8'd7; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    block_ready = 1'b1;
    chk("bp_resume", 256'(block_data), 256'(2));
    @(negedge clk);
    chk("bp_block3", 256'(block_data), 256'(3));
    lat = -1;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (done) lat = c;
    end
    if (lat < 0) chk("bp_done_timeout", 256'(0), 256'(1));
    chk("bp_key_out", 256'(key_out), 256'(4));
    chk("bp_v_out", 256'(v_out), 256'(5));
    chk("bp_ctr_out", 256'(ctr_out), 256'(1));
    // reset while in GEN
    @(negedge clk);
    num_blocks = 8'd5; block_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ar_in_gen", 256'(block_valid), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", {busy, block_valid, done, reseed_required}, 256'(0));
    chk("ar_outputs", {block_data, key_out}, 256'(0));
    chk("ar_outputs2", {v_out, ctr_out}, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ar_no_done", 256'(ndone), 256'(0));
    run(vt[0]);
    check_vec(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
